// File: rtl/dmem_dump_ctrl.sv
// Data-memory port owner: passes core traffic through, and on ecall/dbg_start
// freezes the core and streams dmem words 0..DUMP_WORDS-1 over valid/ready.
module dmem_dump_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DUMP_WORDS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_a,
    input  logic [DATA_W-1:0] core_wd,
    input  logic              core_we,
    output logic [DATA_W-1:0] core_rd,
    input  logic              ecall,
    input  logic              dbg_start,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              core_hold,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_done
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    // Full-width compare: with DUMP_WORDS == 2^ADDR_W this is all-ones, so ptr never wraps.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    assign core_rd = mem_rd;

    always_comb begin
        mem_a  = core_a;
        mem_wd = core_wd;
        mem_we = core_we;
        if (state != IDLE) begin
            mem_a  = ptr;
            mem_wd = '0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_valid <= 1'b0;
            dump_done  <= 1'b0;
            core_hold  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A core write in the trigger cycle still lands: mem_we is passthrough here.
                    if (ecall || dbg_start) begin
                        state     <= FETCH;
                        ptr       <= '0;
                        core_hold <= 1'b1;
                    end
                end
                FETCH: begin
                    dump_data  <= mem_rd;
                    dump_addr  <= ptr;
                    dump_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (ptr == LAST) begin
                            state     <= DONE;
                            dump_done <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Scoreboard bench for dmem_dump_ctrl: three instances cover the default,
// narrow-address (ADDR_W=2, 4 words) and single-word configurations.
module tb_dmem_dump_ctrl;
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] core_a;
    logic [31:0] core_wd;
    logic        core_we, dump_ready;
    logic        ecall_a, dbg_a, ecall_b, dbg_b, ecall_c, dbg_c;

    logic [31:0] rd_a, mwd_a, mrd_a, dd_a;
    logic [15:0] ma_a, da_a;
    logic        mwe_a, hold_a, v_a, done_a;
    logic [31:0] rd_b, mwd_b, mrd_b, dd_b;
    logic [1:0]  ma_b, da_b;
    logic        mwe_b, hold_b, v_b, done_b;
    logic [31:0] rd_c, mwd_c, mrd_c, dd_c;
    logic [15:0] ma_c, da_c;
    logic        mwe_c, hold_c, v_c, done_c;

    logic [31:0] marr_a [256];
    logic [31:0] marr_b [4];
    logic [31:0] marr_c [256];
    assign mrd_a = marr_a[ma_a[7:0]];
    assign mrd_b = marr_b[ma_b];
    assign mrd_c = marr_c[ma_c[7:0]];
    always @(posedge clk) begin
        if (mwe_a) marr_a[ma_a[7:0]] <= mwd_a;
        if (mwe_b) marr_b[ma_b] <= mwd_b;
        if (mwe_c) marr_c[ma_c[7:0]] <= mwd_c;
    end

    dmem_dump_ctrl #(.DATA_W(32), .ADDR_W(16), .DUMP_WORDS(200)) u_a (
        .clk(clk), .rst(rst), .core_a(core_a), .core_wd(core_wd), .core_we(core_we),
        .core_rd(rd_a), .ecall(ecall_a), .dbg_start(dbg_a), .mem_a(ma_a), .mem_wd(mwd_a),
        .mem_we(mwe_a), .mem_rd(mrd_a), .core_hold(hold_a), .dump_valid(v_a),
        .dump_ready(dump_ready), .dump_data(dd_a), .dump_addr(da_a), .dump_done(done_a));

    dmem_dump_ctrl #(.DATA_W(32), .ADDR_W(2), .DUMP_WORDS(4)) u_b (
        .clk(clk), .rst(rst), .core_a(core_a[1:0]), .core_wd(core_wd), .core_we(core_we),
        .core_rd(rd_b), .ecall(ecall_b), .dbg_start(dbg_b), .mem_a(ma_b), .mem_wd(mwd_b),
        .mem_we(mwe_b), .mem_rd(mrd_b), .core_hold(hold_b), .dump_valid(v_b),
        .dump_ready(dump_ready), .dump_data(dd_b), .dump_addr(da_b), .dump_done(done_b));

    dmem_dump_ctrl #(.DATA_W(32), .ADDR_W(16), .DUMP_WORDS(1)) u_c (
        .clk(clk), .rst(rst), .core_a(core_a), .core_wd(core_wd), .core_we(core_we),
        .core_rd(rd_c), .ecall(ecall_c), .dbg_start(dbg_c), .mem_a(ma_c), .mem_wd(mwd_c),
        .mem_we(mwe_c), .mem_rd(mrd_c), .core_hold(hold_c), .dump_valid(v_c),
        .dump_ready(dump_ready), .dump_data(dd_c), .dump_addr(da_c), .dump_done(done_c));

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic        o_v, o_done, o_hold, o_we;
    logic [15:0] o_addr;
    logic [31:0] o_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel);
        @(negedge clk);
        case (sel)
            0: begin o_v = v_a; o_done = done_a; o_hold = hold_a; o_we = mwe_a; o_addr = da_a; o_data = dd_a; end
            1: begin o_v = v_b; o_done = done_b; o_hold = hold_b; o_we = mwe_b; o_addr = {14'd0, da_b}; o_data = dd_b; end
            default: begin o_v = v_c; o_done = done_c; o_hold = hold_c; o_we = mwe_c; o_addr = da_c; o_data = dd_c; end
        endcase
    endtask

    task automatic test_reset;
        rst = 1'b1; core_a = 16'h1234; core_wd = 32'hA5A5_0001; core_we = 1'b0; dump_ready = 1'b1;
        ecall_a = 0; dbg_a = 0; ecall_b = 0; dbg_b = 0; ecall_c = 0; dbg_c = 0;
        sample(0);
        checks++;
        if ({o_v, o_done, o_hold, o_addr, o_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b done=%b hold=%b addr=%h data=%h required all 0",
                     o_v, o_done, o_hold, o_addr, o_data);
        end
        checks++;
        if (ma_a !== 16'h1234 || mwd_a !== 32'hA5A5_0001 || o_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_passthrough got a=%h wd=%h we=%b required a=1234 wd=a5a50001 we=0", ma_a, mwd_a, o_we);
        end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_passthrough;
        core_a = 16'd3; core_wd = 32'hDEAD_BEEF; core_we = 1'b1;
        sample(0);
        checks++;
        if (o_we !== 1'b1 || ma_a !== 16'd3 || mwd_a !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL pass_write got we=%b a=%h wd=%h required we=1 a=0003 wd=deadbeef", o_we, ma_a, mwd_a);
        end
        tick;
        core_we = 1'b0; core_wd = 32'h0;
        sample(0);
        checks++;
        if (rd_a !== 32'hDEAD_BEEF || o_we !== 1'b0) begin
            errors++;
            $display("FAIL pass_read got rd=%h we=%b required rd=deadbeef we=0", rd_a, o_we);
        end
        tick;
    endtask

    task automatic preload;
        for (int i = 0; i < 200; i++) begin
            core_a = 16'(i); core_wd = 32'(i * 4 + 1); core_we = 1'b1;
            tick;
        end
        core_we = 1'b0;
    endtask

    // Word 1 gets ready low for its FETCH cycle plus two SEND cycles.
    task automatic test_backpressure;
        exp_t e;
        int done_at = 0, xfers = 0, stalls = 0;
        q.delete();
        for (int j = 0; j < 4; j++) q.push_back('{16'(j), 32'((196 + j) * 4 + 1)});
        ecall_b = 1'b1; tick; ecall_b = 1'b0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            dump_ready = !(i >= 3 && i <= 5);
            sample(1);
            if (o_v) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra got addr=%0d required no transfer", o_addr);
                end else begin
                    e = q[0];
                    if (o_addr !== e.addr || o_data !== e.data) begin
                        errors++;
                        $display("FAIL bp_word cycle=%0d got addr=%0d data=%h required addr=%0d data=%h",
                                 i, o_addr, o_data, e.addr, e.data);
                    end
                    if (dump_ready) begin void'(q.pop_front()); xfers++; end
                    else stalls++;
                end
            end
            if (o_done) done_at = i;
            tick;
        end
        dump_ready = 1'b1;
        checks++;
        if (done_at != 11 || xfers != 4 || stalls != 2 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_summary got done_at=%0d xfers=%0d stalls=%0d left=%0d required 11 4 2 0",
                     done_at, xfers, stalls, q.size());
        end
        for (int i = 0; i < 4; i++) begin
            sample(1);
            checks++;
            if (o_v !== 1'b0 || o_done !== 1'b1 || o_hold !== 1'b1) begin
                errors++;
                $display("FAIL bp_sticky got v=%b done=%b hold=%b required 0 1 1", o_v, o_done, o_hold);
            end
            tick;
        end
    endtask

    task automatic test_single;
        int done_at = 0, xfers = 0;
        ecall_c = 1'b1; dbg_c = 1'b1; tick; ecall_c = 1'b0; dbg_c = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            sample(2);
            if (o_v) begin
                xfers++;
                checks++;
                if (o_addr !== 16'd0 || o_data !== 32'd1) begin
                    errors++;
                    $display("FAIL single_word got addr=%0d data=%h required addr=0 data=00000001", o_addr, o_data);
                end
            end
            if (o_done && done_at == 0) done_at = i;
            tick;
        end
        checks++;
        if (xfers != 1 || done_at != 3) begin
            errors++;
            $display("FAIL single_summary got xfers=%0d done_at=%0d required 1 3", xfers, done_at);
        end
    endtask

    task automatic test_full_dump;
        exp_t e;
        int done_at = 0, xfers = 0;
        q.delete();
        for (int i = 0; i < 200; i++) q.push_back('{16'(i), 32'(i * 4 + 1)});
        ecall_a = 1'b1; tick; ecall_a = 1'b0;
        core_we = 1'b1; core_a = 16'd7; core_wd = 32'hFFFF_FFFF;
        for (int i = 1; i <= 450 && done_at == 0; i++) begin
            sample(0);
            checks++;
            if (o_we !== 1'b0 || o_hold !== 1'b1) begin
                errors++;
                $display("FAIL full_hold cycle=%0d got we=%b hold=%b required 0 1", i, o_we, o_hold);
            end
            if (o_v) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL full_extra got addr=%0d required no transfer", o_addr);
                end else begin
                    e = q.pop_front();
                    if (o_addr !== e.addr || o_data !== e.data || i != 2 + 2 * xfers) begin
                        errors++;
                        $display("FAIL full_word cycle=%0d got addr=%0d data=%h required cycle=%0d addr=%0d data=%h",
                                 i, o_addr, o_data, 2 + 2 * xfers, e.addr, e.data);
                    end
                end
                xfers++;
            end
            if (o_done) done_at = i;
            tick;
        end
        core_we = 1'b0;
        checks++;
        if (done_at != 401 || xfers != 200 || q.size() != 0) begin
            errors++;
            $display("FAIL full_summary got done_at=%0d xfers=%0d left=%0d required 401 200 0", done_at, xfers, q.size());
        end
    endtask

    task automatic test_trigger_write;
        exp_t e;
        int xfers = 0;
        rst = 1'b1; tick; rst = 1'b0; tick;
        q.delete();
        q.push_back('{16'd0, 32'h1234_5678});
        q.push_back('{16'd1, 32'd5});
        q.push_back('{16'd2, 32'd9});
        core_a = 16'd0; core_wd = 32'h1234_5678; core_we = 1'b1; ecall_a = 1'b1;
        tick;
        core_we = 1'b0; ecall_a = 1'b0;
        for (int i = 1; i <= 20 && xfers < 3; i++) begin
            sample(0);
            if (o_v) begin
                e = q.pop_front();
                checks++;
                if (o_addr !== e.addr || o_data !== e.data) begin
                    errors++;
                    $display("FAIL trig_word got addr=%0d data=%h required addr=%0d data=%h", o_addr, o_data, e.addr, e.data);
                end
                xfers++;
            end
            tick;
        end
        checks++;
        if (xfers != 3) begin
            errors++;
            $display("FAIL trig_count got %0d required 3", xfers);
        end
    endtask

    task automatic test_reset_mid;
        int first = 0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({v_a, done_a, hold_a, da_a, dd_a} !== '0 || ma_a !== core_a) begin
            errors++;
            $display("FAIL mid_reset got v=%b done=%b hold=%b addr=%h data=%h mem_a=%h required zeros mem_a=%h",
                     v_a, done_a, hold_a, da_a, dd_a, ma_a, core_a);
        end
        tick;
        rst = 1'b0;
        dbg_a = 1'b1; tick; dbg_a = 1'b0;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            sample(0);
            if (o_v) begin
                first = i;
                checks++;
                if (o_addr !== 16'd0 || o_data !== 32'h1234_5678 || i != 2) begin
                    errors++;
                    $display("FAIL retrigger got cycle=%0d addr=%0d data=%h required cycle=2 addr=0 data=12345678",
                             i, o_addr, o_data);
                end
            end
            tick;
        end
        checks++;
        if (first == 0) begin
            errors++;
            $display("FAIL retrigger_timeout got no valid required word 0");
        end
    endtask

    initial begin
        test_reset;
        test_passthrough;
        preload;
        test_backpressure;
        test_single;
        test_full_dump;
        test_trigger_write;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
